stream_demux: RTL and testbench

- Parametrised, registered successor to the 1-to-8 combinational demultiplexer.
- Routes one DATA_W-bit input stream to one of N_OUT = 2**SEL_W output channels, or to all of them in broadcast mode.
- Uses valid/ready handshakes on both sides, with a one-entry holding register per output channel.
- Sits between a single producer and N independent consumers, e.g. a lab datapath fanning results out to per-unit queues.

---
 rtl/demux_pkg.sv | 18 +
 rtl/demux_slot.sv | 40 ++++
 rtl/stream_demux.sv | 85 ++++++++
 tb/tb_stream_demux.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the registered stream demultiplexer: default widths,
// channel-count derivation and the flat-bus slice helper.
package demux_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int SEL_W_DEF  = 3;
    localparam int CNT_W_DEF  = 16;

    function automatic int n_out(input int sel_w);
        return 1 << sel_w;
    endfunction

    // Low bit of channel i inside the flat out_data bus
    function automatic int slice_lo(input int i, input int data_w);
        return i * data_w;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel. A drain in the same
// cycle as a load lets the new word replace the old one.
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              slot_free
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;

    // Holding register: load has priority over drain; the payload is kept when invalid
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else if (valid_r && out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign slot_free = ~valid_r | out_ready;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with unicast and broadcast delivery,
// valid/ready on both sides and a count of accepted input transfers.
module stream_demux
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    localparam int N_OUT = n_out(SEL_W)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]        xfer_cnt
);

    logic [N_OUT-1:0] slot_free_s;
    logic [N_OUT-1:0] load_s;
    logic             ready_s;
    logic             accept_s;
    logic [CNT_W-1:0] xfer_cnt_r;

    // Ready: a broadcast waits until every slot can take the word at once
    always_comb begin
        ready_s = 1'b0;
        if (reset) begin
            ready_s = 1'b0;
        end else if (in_bcast) begin
            ready_s = &slot_free_s;
        end else begin
            ready_s = slot_free_s[in_sel];
        end
    end

    assign accept_s = in_valid & ready_s;
    assign in_ready = ready_s;

    // Select decode: which slots capture the accepted word
    always_comb begin
        load_s = {N_OUT{1'b0}};
        if (accept_s && in_bcast) begin
            load_s = {N_OUT{1'b1}};
        end else if (accept_s) begin
            load_s[in_sel] = 1'b1;
        end else begin
            load_s = {N_OUT{1'b0}};
        end
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load_s[i]),
            .load_data (in_data),
            .out_ready (out_ready[i]),
            .out_valid (out_valid[i]),
            .out_data  (out_data[slice_lo(i, DATA_W) +: DATA_W]),
            .slot_free (slot_free_s[i])
        );
    end

    // Transfer counter: one step per accepted input word, wrapping naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            xfer_cnt_r <= xfer_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            xfer_cnt_r <= xfer_cnt_r;
        end
    end

    assign xfer_cnt = xfer_cnt_r;

endmodule

// File: tb/tb_stream_demux.sv
// Directed, table-driven bench for stream_demux; a second instance with a
// 4-bit counter shares the stimulus to exercise counter wrap.
module tb_stream_demux;
    import demux_pkg::*;

    localparam int DW = 8;
    localparam int SW = 3;
    localparam int NO = 8;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [SW-1:0]     in_sel;
    logic              in_bcast;
    logic [NO-1:0]     out_valid;
    logic [NO-1:0]     out_ready;
    logic [NO*DW-1:0]  out_data;
    logic [15:0]       xfer_cnt;

    logic              in_ready4;
    logic [NO-1:0]     out_valid4;
    logic [NO*DW-1:0]  out_data4;
    logic [3:0]        xfer_cnt4;

    int n_tests = 0;
    int n_fail  = 0;

    stream_demux #(.DATA_W(DW), .SEL_W(SW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .xfer_cnt(xfer_cnt)
    );

    stream_demux #(.DATA_W(DW), .SEL_W(SW), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .xfer_cnt(xfer_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] chan(input logic [NO*DW-1:0] bus, input int i);
        return bus[slice_lo(i, DW) +: DW];
    endfunction

    // mode: 0 = no data check, 1 = check channel ch, 2 = check whole bus
    typedef struct {
        logic        v;
        logic        b;
        logic [2:0]  sel;
        logic [7:0]  data;
        logic [7:0]  ordy;
        logic        exp_rdy;
        logic [7:0]  exp_ov;
        logic [1:0]  mode;
        logic [2:0]  ch;
        logic [7:0]  exp_ch;
        logic [63:0] exp_bus;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[15];

    initial begin
        //            v     b     sel   data   ordy   rdy   ov     mode  ch    exp_ch bus            cnt
        vecs[0]  = '{1'b1, 1'b0, 3'd2, 8'hA5, 8'hFF, 1'b1, 8'h04, 2'd1, 3'd2, 8'hA5, 64'h0, 16'd1};
        vecs[1]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 2'd0, 3'd0, 8'h00, 64'h0, 16'd1};
        vecs[2]  = '{1'b1, 1'b0, 3'd5, 8'h11, 8'hDF, 1'b1, 8'h20, 2'd1, 3'd5, 8'h11, 64'h0, 16'd2};
        vecs[3]  = '{1'b1, 1'b0, 3'd5, 8'h22, 8'hDF, 1'b0, 8'h20, 2'd1, 3'd5, 8'h11, 64'h0, 16'd2};
        vecs[4]  = '{1'b1, 1'b0, 3'd5, 8'h22, 8'hFF, 1'b1, 8'h20, 2'd1, 3'd5, 8'h22, 64'h0, 16'd3};
        vecs[5]  = '{1'b0, 1'b0, 3'd5, 8'h00, 8'hFF, 1'b1, 8'h00, 2'd0, 3'd0, 8'h00, 64'h0, 16'd3};
        vecs[6]  = '{1'b1, 1'b1, 3'd0, 8'h3C, 8'h00, 1'b1, 8'hFF, 2'd2, 3'd0, 8'h00,
                     64'h3C3C3C3C_3C3C3C3C, 16'd4};
        vecs[7]  = '{1'b1, 1'b0, 3'd7, 8'h77, 8'h7F, 1'b0, 8'h80, 2'd1, 3'd7, 8'h3C, 64'h0, 16'd4};
        vecs[8]  = '{1'b1, 1'b1, 3'd0, 8'h99, 8'h7F, 1'b0, 8'h80, 2'd1, 3'd7, 8'h3C, 64'h0, 16'd4};
        vecs[9]  = '{1'b1, 1'b1, 3'd0, 8'h99, 8'hFF, 1'b1, 8'hFF, 2'd2, 3'd0, 8'h00,
                     64'h99999999_99999999, 16'd5};
        vecs[10] = '{1'b1, 1'b0, 3'd4, 8'h44, 8'hEF, 1'b0, 8'h10, 2'd1, 3'd4, 8'h99, 64'h0, 16'd5};
        vecs[11] = '{1'b1, 1'b0, 3'd6, 8'h44, 8'hEF, 1'b1, 8'h50, 2'd1, 3'd6, 8'h44, 64'h0, 16'd6};
        vecs[12] = '{1'b1, 1'b1, 3'd0, 8'h55, 8'h00, 1'b0, 8'h50, 2'd1, 3'd4, 8'h99, 64'h0, 16'd6};
        vecs[13] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h50, 2'd1, 3'd6, 8'h44, 64'h0, 16'd6};
        vecs[14] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 2'd0, 3'd0, 8'h00, 64'h0, 16'd6};

        // Reset with a word offered: nothing may be accepted
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        in_sel    = 3'd1;
        in_bcast  = 1'b0;
        out_ready = 8'hFF;
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 3'd0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 15; i++) begin
            in_valid  = vecs[i].v;
            in_bcast  = vecs[i].b;
            in_sel    = vecs[i].sel;
            in_data   = vecs[i].data;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_rdy));
            tick();
            check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            check($sformatf("v%0d_xfer_cnt", i), 64'(xfer_cnt), 64'(vecs[i].exp_cnt));
            check($sformatf("v%0d_xfer_cnt4", i), 64'(xfer_cnt4), 64'(vecs[i].exp_cnt[3:0]));
            if (vecs[i].mode == 2'd1) begin
                check($sformatf("v%0d_ch%0d_data", i, vecs[i].ch),
                      64'(chan(out_data, int'(vecs[i].ch))), 64'(vecs[i].exp_ch));
            end else if (vecs[i].mode == 2'd2) begin
                check($sformatf("v%0d_bus", i), out_data, vecs[i].exp_bus);
            end
        end

        // Reset mid-operation with channels 1 and 3 holding words
        in_bcast  = 1'b0;
        out_ready = 8'h00;
        in_valid  = 1'b1;
        in_sel    = 3'd1;
        in_data   = 8'h01;
        tick();
        in_sel    = 3'd3;
        in_data   = 8'h03;
        tick();
        check("mid_held_valid", 64'(out_valid), 64'h0A);
        reset     = 1'b1;
        in_sel    = 3'd2;
        out_ready = 8'hFF;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_cnt", 64'(xfer_cnt), 64'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("mid_after_valid", 64'(out_valid), 64'd0);

        // Back-to-back stream into channel 0
        out_ready = 8'h01;
        in_sel    = 3'd0;
        for (int k = 0; k < 16; k++) begin
            logic [7:0] d;
            d        = 8'h80 + 8'(k);
            in_valid = 1'b1;
            in_data  = d;
            #1;
            check($sformatf("tp%0d_in_ready", k), 64'(in_ready), 64'd1);
            tick();
            check($sformatf("tp%0d_out_valid", k), 64'(out_valid), 64'h01);
            check($sformatf("tp%0d_data", k), 64'(chan(out_data, 0)), 64'(d));
        end
        in_valid = 1'b0;
        tick();
        check("tp_drained", 64'(out_valid), 64'd0);
        check("tp_xfer_cnt", 64'(xfer_cnt), 64'd16);
        check("tp_xfer_cnt4", 64'(xfer_cnt4), 64'd0);

        // Counter wrap: 17 transfers on the 4-bit instance
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 17; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("wrap_cnt16", 64'(xfer_cnt), 64'd17);
        check("wrap_cnt4", 64'(xfer_cnt4), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
